// File: rtl/jinverter_pkg.sv
// Shared constants, edge-polarity type and the saturating increment used by
// both transition counters of the jinverter block.
package jinverter_pkg;

   localparam int WIDTH_DEF = 1;
   localparam int CNT_W_DEF = 16;

   // Widest counter the shared increment helper can serve.
   localparam int CNT_W_MAX = 32;

   typedef enum logic {
      RISE = 1'b0,
      FALL = 1'b1
   } edgePol_e;

   // Adds one to a counter of the given width, holding at all-ones instead
   // of wrapping. Values are carried zero-extended to CNT_W_MAX bits.
   function automatic logic [CNT_W_MAX-1:0] satInc(
      input logic [CNT_W_MAX-1:0] value,
      input int                   width
   );
      logic [CNT_W_MAX-1:0] maxVal;
      maxVal = (width >= CNT_W_MAX) ? '1
                                    : ((CNT_W_MAX'(1) << width) - CNT_W_MAX'(1));
      return (value >= maxVal) ? value : value + CNT_W_MAX'(1);
   endfunction

endpackage

// File: rtl/jinverter_edge_cnt.sv
// Samples one data bit, detects a transition of the selected polarity and
// counts it in a saturating counter with a synchronous clear.
module jinverter_edge_cnt
   import jinverter_pkg::*;
#(
   parameter int       CNT_W = CNT_W_DEF,
   parameter edgePol_e POL   = RISE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             bit_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic             aPrev_q;
   logic             edgeHit;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Previous sample resets to 0 so a high input on the first clock counts as a rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aPrev_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         aPrev_q <= bit_i;
         cnt_q   <= cnt_d;
      end
   end

   // Clear wins over a same-cycle edge; otherwise count the edge, holding at all-ones.
   always_comb begin
      edgeHit = (POL == RISE) ? (!aPrev_q &&  bit_i)
                              : ( aPrev_q && !bit_i);
      cnt_d   = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (edgeHit) begin
         cnt_d = CNT_W'(satInc(CNT_W_MAX'(cnt_q), CNT_W));
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/jinverter.sv
// Bitwise inverter with a registered copy of the output and rise/fall
// statistics on bit 0. Port order keeps two-port (y, a) instances legal.
module jinverter
   import jinverter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   output logic [WIDTH-1:0] y,
   input  logic [WIDTH-1:0] a,
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   output logic [WIDTH-1:0] y_q,
   output logic [CNT_W-1:0] rise_cnt,
   output logic [CNT_W-1:0] fall_cnt
);

   logic [WIDTH-1:0] yReg_q;
   logic [WIDTH-1:0] yReg_d;

   // Zero-latency inversion, independent of clock and reset.
   assign y      = ~a;
   assign yReg_d = ~a;

   // Registered copy; reset value matches an input of all zeros.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         yReg_q <= '1;
      end else begin
         yReg_q <= yReg_d;
      end
   end

   assign y_q = yReg_q;

   jinverter_edge_cnt #(
      .CNT_W (CNT_W),
      .POL   (RISE)
   ) uRiseCnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (clr),
      .bit_i (a[0]),
      .cnt_o (rise_cnt)
   );

   jinverter_edge_cnt #(
      .CNT_W (CNT_W),
      .POL   (FALL)
   ) uFallCnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (clr),
      .bit_i (a[0]),
      .cnt_o (fall_cnt)
   );

endmodule

// File: tb/tb_jinverter.sv
// Bench for jinverter: three instances (1-bit, 8-bit, 2-bit-counter) driven
// together and compared against a behavioural model of the inversion and
// transition-counting rules.
module tb_jinverter;

   logic clk    = 1'b0;
   logic clkEn  = 1'b0;
   logic rstN   = 1'b1;

   logic        a1   = 1'b0;
   logic        clr1 = 1'b0;
   logic        y1, yq1;
   logic [15:0] rise1, fall1;

   logic [7:0]  a8   = 8'h00;
   logic        clr8 = 1'b0;
   logic [7:0]  y8, yq8;
   logic [15:0] rise8, fall8;

   logic        aS   = 1'b0;
   logic        clrS = 1'b0;
   logic        yS, yqS;
   logic [1:0]  riseS, fallS;

   int checks   = 0;
   int failures = 0;

   // Model state: previous sampled bit 0, counts, expected registered output.
   bit       m1Prev, m8Prev, mSPrev;
   int       m1Rise, m1Fall, m8Rise, m8Fall, mSRise, mSFall;
   logic     m1Yq, mSYq;
   logic [7:0] m8Yq;

   // Free-running clock once enabled; idle while combinational paths are probed.
   always #5 if (clkEn) clk = ~clk;

   jinverter #(.WIDTH(1), .CNT_W(16)) dut1 (
      .y(y1), .a(a1), .clk(clk), .rst_n(rstN), .clr(clr1),
      .y_q(yq1), .rise_cnt(rise1), .fall_cnt(fall1));

   jinverter #(.WIDTH(8), .CNT_W(16)) dut8 (
      .y(y8), .a(a8), .clk(clk), .rst_n(rstN), .clr(clr8),
      .y_q(yq8), .rise_cnt(rise8), .fall_cnt(fall8));

   jinverter #(.WIDTH(1), .CNT_W(2)) dutSat (
      .y(yS), .a(aS), .clk(clk), .rst_n(rstN), .clr(clrS),
      .y_q(yqS), .rise_cnt(riseS), .fall_cnt(fallS));

   // Compares one observed value with the expected one and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Next count: clear forces zero, an edge adds one up to the ceiling.
   function automatic int nextCnt(input int cnt, input int maxVal,
                                  input bit hit, input bit clr);
      if (clr) return 0;
      if (hit) return (cnt < maxVal) ? cnt + 1 : cnt;
      return cnt;
   endfunction

   task automatic resetModel();
      m1Prev = 0; m8Prev = 0; mSPrev = 0;
      m1Rise = 0; m1Fall = 0; m8Rise = 0; m8Fall = 0; mSRise = 0; mSFall = 0;
      m1Yq = 1'b1; m8Yq = 8'hFF; mSYq = 1'b1;
   endtask

   task automatic checkRegs();
      checkOutput("yq1",   32'(yq1),   32'(m1Yq));
      checkOutput("rise1", 32'(rise1), 32'(m1Rise));
      checkOutput("fall1", 32'(fall1), 32'(m1Fall));
      checkOutput("yq8",   32'(yq8),   32'(m8Yq));
      checkOutput("rise8", 32'(rise8), 32'(m8Rise));
      checkOutput("fall8", 32'(fall8), 32'(m8Fall));
      checkOutput("yqS",   32'(yqS),   32'(mSYq));
      checkOutput("riseS", 32'(riseS), 32'(mSRise));
      checkOutput("fallS", 32'(fallS), 32'(mSFall));
   endtask

   // Drives one cycle of inputs (called just after a rising edge), checks the
   // combinational outputs, then advances the model on the next edge and checks.
   task automatic applyStimulus(input logic v1, input logic [7:0] v8, input logic vS,
                                input logic c1, input logic c8, input logic cS);
      logic       inv1, invS;
      logic [7:0] inv8;
      a1 = v1; a8 = v8; aS = vS;
      clr1 = c1; clr8 = c8; clrS = cS;
      inv1 = ~v1; inv8 = ~v8; invS = ~vS;
      #1;
      checkOutput("y1_comb", 32'(y1), 32'(inv1));
      checkOutput("y8_comb", 32'(y8), 32'(inv8));
      checkOutput("yS_comb", 32'(yS), 32'(invS));
      @(posedge clk);
      m1Rise = nextCnt(m1Rise, 65535, !m1Prev &&  v1, c1);
      m1Fall = nextCnt(m1Fall, 65535,  m1Prev && !v1, c1);
      m1Prev = v1; m1Yq = inv1;
      m8Rise = nextCnt(m8Rise, 65535, !m8Prev &&  v8[0], c8);
      m8Fall = nextCnt(m8Fall, 65535,  m8Prev && !v8[0], c8);
      m8Prev = v8[0]; m8Yq = inv8;
      mSRise = nextCnt(mSRise, 3, !mSPrev &&  vS, cS);
      mSFall = nextCnt(mSFall, 3,  mSPrev && !vS, cS);
      mSPrev = vS; mSYq = invS;
      #1;
      checkRegs();
   endtask

   initial begin
      resetModel();
      #1 rstN = 1'b0;
      #10;
      $display("[TB] reset state");
      checkRegs();

      $display("[TB] combinational inversion with clock idle");
      a1 = 1'b1; #100 checkOutput("comb_a1", 32'(y1), 32'd0);
      a1 = 1'b0; #100 checkOutput("comb_a0", 32'(y1), 32'd1);
      a1 = 1'b1; #50  checkOutput("comb_a1_50", 32'(y1), 32'd0);
      a1 = 1'b0; #100 checkOutput("comb_a0_b", 32'(y1), 32'd1);
      a8 = 8'hA5; #1  checkOutput("comb_a5", 32'(y8), 32'h5A);
      checkOutput("yq1_held_in_reset", 32'(yq1), 32'd1);
      a8 = 8'h00;

      clkEn = 1'b1;
      @(negedge clk) rstN = 1'b1;
      @(posedge clk); #1;

      $display("[TB] directed counting and saturation");
      begin
         logic       pat1 [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
         logic [7:0] pat8;
         for (int i = 0; i < 10; i++) begin
            pat8 = (i == 0) ? 8'hA5 : 8'($urandom);
            applyStimulus(pat1[i], pat8, 1'((i + 1) % 2), 1'b0, 1'b0, 1'b0);
            if (i == 0) checkOutput("yq8_a5", 32'(yq8), 32'h5A);
            if (i == 4) begin
               checkOutput("rise1_two", 32'(rise1), 32'd2);
               checkOutput("fall1_two", 32'(fall1), 32'd2);
            end
         end
      end
      checkOutput("riseS_sat", 32'(riseS), 32'd3);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("riseS_clr_edge", 32'(riseS), 32'd0);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 200; i++) begin
         applyStimulus(1'($urandom), 8'($urandom), 1'($urandom),
                       ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 7) == 0));
      end

      $display("[TB] asynchronous reset mid-operation");
      applyStimulus(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h32, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("yq1_zero_pre", 32'(yq1), 32'd0);
      checkOutput("rise1_nz_pre", 32'(rise1 != 16'd0), 32'd1);
      checkOutput("fall1_nz_pre", 32'(fall1 != 16'd0), 32'd1);
      #2 rstN = 1'b0;
      #1;
      resetModel();
      checkRegs();
      checkOutput("y1_in_reset", 32'(y1), 32'd0);
      checkOutput("y8_in_reset", 32'(y8), 32'h3C);

      @(negedge clk) rstN = 1'b1;
      @(posedge clk); #1;
      applyStimulus(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("rise1_first_after_reset", 32'(rise1), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/jinverter.md
# jinverter

Bitwise logic inverter with optional clocked observability. Output `y` is the combinational complement of input `a` with zero latency. A registered copy and transition statistics are kept in the `clk` domain for debug and status readout. The block sits on any control/data line that needs polarity inversion; legacy positional instances that connect only `(y, a)` remain valid.

## Interface
- `WIDTH`, default 1: bit width of `a`, `y` and `y_q`.
- `CNT_W`, default 16: width of each transition counter.
- Declaration order is fixed as `y, a, clk, rst_n, clr, y_q, rise_cnt, fall_cnt`, so two-port positional instances stay legal.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset. Assertion is asynchronous; release is synchronous to `clk`.
- `y`, output, WIDTH: `~a`, purely combinational.
- `a`, input, WIDTH: data in.
- `clr`, input, 1: synchronous clear of the counters.
- `y_q`, output, WIDTH: `~a`, registered.
- `rise_cnt`, output, CNT_W: number of 0→1 transitions seen on `a[0]`.
- `fall_cnt`, output, CNT_W: number of 1→0 transitions seen on `a[0]`.

## Operation
- `y = ~a` bitwise at all times.
  - Independent of `clk`, `rst_n` and `clr`.
  - X/Z on an input bit gives X on the matching output bit.
- `a_d` is an internal register sampling `a` every clock.
- `y_q` updates each clock to `~a` as sampled.
- Edge detection on bit 0:
  - Rise when `a_d[0]==0 && a[0]==1`.
  - Fall when `a_d[0]==1 && a[0]==0`.
- Each counter increments by 1 on its edge and saturates at all-ones; it does not wrap.
- `clr` has priority over an increment in the same cycle: the counter goes to 0 and that edge is dropped.
- Reset (`rst_n=0`), asynchronous:
  - `y_q` goes to all-ones, consistent with `a=0`.
  - `a_d` goes to 0.
  - Both counters go to 0.
  - `y` is unaffected.
- First clock after reset release: a rise is counted if `a[0]==1`, because `a_d` was reset to 0.

## Timing
- `y`: 0 cycles, delta-delay only.
  - Must be settled well before any checker samples.
  - Sampling 50 time units after an input change must see the correct value.
- `y_q`, `rise_cnt`, `fall_cnt`: 1-cycle latency from `a`/`clr` at the sampling clock edge.
- Reset asserted mid-operation clears the registers immediately, with no clock needed. `y` keeps tracking `a`.
- Simultaneous `clr` and edge: the result is 0.
- Counter at max and a new edge: the counter holds at max.

## Structure
- Package `jinverter_pkg`:
  - `CNT_W_DEF` = 16.
  - `WIDTH_DEF` = 1.
  - A saturating-increment function, shared by both counters.
- One sub-module, `jinverter_edge_cnt`.
  - Contains: the `a_d` register, the edge detection, and one saturating counter with `clr`.
  - Instantiated twice, once with polarity `RISE` and once with `FALL`.
- The top-level holds the combinational `y` and the `y_q` register.

## Test plan
- Combinational inversion, `WIDTH=1`, `clk` idle:
  - Drive `a=1`, wait 100 → `y==0`.
  - Then `a=0`, wait 100 → `y==1`.
  - Then `a=1`, wait 50 → `y==0`.
  - Then `a=0`, wait 100 → `y==1`.
- `WIDTH=8`: `a=8'hA5` → `y==8'h5A` immediately; `y_q==8'h5A` after one clock.
- Async reset: counters nonzero and `y_q=0`; pull `rst_n` low between clock edges → counters 0 and `y_q` all-ones at once; `y` still equals `~a`.
- Counting: toggle `a[0]` as 0,1,0,1,0 on successive clocks → `rise_cnt==2`, `fall_cnt==2`.
- Saturation and clear, `CNT_W=2`:
  - 5 rises → `rise_cnt==3`.
  - Assert `clr` in the same cycle as a rise → `rise_cnt==0` next cycle.
